// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline boundary: control-bundle bit map,
// register index width and the bypass selection rule.
package id_ex_stage_pkg;

    localparam int unsigned CTRL_W = 10;
    localparam int unsigned REG_W  = 5;

    // Bit positions inside the decoded control bundle
    localparam int unsigned ALU_OP_LSB = 0;
    localparam int unsigned ALU_OP_MSB = 3;
    localparam int unsigned ALU_SRC    = 4;
    localparam int unsigned MEM_READ   = 5;
    localparam int unsigned MEM_WRITE  = 6;
    localparam int unsigned REG_WRITE  = 7;
    localparam int unsigned MEM_TO_REG = 8;
    localparam int unsigned BRANCH     = 9;

    localparam logic [REG_W-1:0] X0 = 5'd0;

    // True when the writeback port targets this source register (x0 is never bypassed)
    function automatic logic bypass_hit(input logic             wb_we,
                                        input logic [REG_W-1:0] wb_rd,
                                        input logic [REG_W-1:0] rs);
        return wb_we && (wb_rd != X0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, writeback bypass port, flush and the registered EX-side
// outputs of the ID/EX boundary.
interface id_ex_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 10
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_data1;
    logic [XLEN-1:0]   id_data2;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;

    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              flush;
    logic              stall;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_op_a;
    logic [XLEN-1:0]   ex_op_b;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    // Upstream/environment side: drives ID, WB and flush, observes EX and stall
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_data1, id_data2, id_imm, id_ctrl,
        output wb_reg_write, wb_rd, wb_data, flush,
        input  stall, ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b, ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );

    // Pipeline-stage side
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_data1, id_data2, id_imm, id_ctrl,
        input  wb_reg_write, wb_rd, wb_data, flush,
        output stall, ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b, ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: stalls when the load in EX writes a register the
// ID instruction reads. Both rs fields are always compared (conservative).
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             flush,
    output logic             stall
);

    logic rd_match;

    // Hazard condition; flush and reset both suppress the stall
    always_comb begin
        stall    = 1'b0;
        rd_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        if (!rst && !flush && id_valid && ex_valid && ex_mem_read && (ex_rd != X0) && rd_match) begin
            stall = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID write-through bypass, load-use bubble
// insertion, flush squash and a saturating bubble counter.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    import id_ex_stage_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              stall_c;
    logic [XLEN-1:0]   op_a_c;
    logic [XLEN-1:0]   op_b_c;

    logic              ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
    logic [XLEN-1:0]   ex_op_a_q,    ex_op_a_d;
    logic [XLEN-1:0]   ex_op_b_q,    ex_op_b_d;
    logic [REG_W-1:0]  ex_rs1_q,     ex_rs1_d;
    logic [REG_W-1:0]  ex_rs2_q,     ex_rs2_d;
    logic [REG_W-1:0]  ex_rd_q,      ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    id_ex_stage_hazard_detect u_hazard (
        .rst         (rst),
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q[MEM_READ]),
        .ex_rd       (ex_rd_q),
        .flush       (bus.flush),
        .stall       (stall_c)
    );

    // Write-through bypass: the register file writes on the same edge it is read
    always_comb begin
        op_a_c = bus.id_data1;
        op_b_c = bus.id_data2;
        if (bypass_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs1)) begin
            op_a_c = bus.wb_data;
        end
        if (bypass_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs2)) begin
            op_b_c = bus.wb_data;
        end
    end

    // Next-state selection: flush beats stall beats load
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        ex_op_a_d    = ex_op_a_q;
        ex_op_b_d    = ex_op_b_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_ctrl_d    = ex_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (stall_c) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d = bus.id_valid;
            ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
            ex_pc_d    = bus.id_pc;
            ex_imm_d   = bus.id_imm;
            ex_op_a_d  = op_a_c;
            ex_op_b_d  = op_b_c;
            ex_rs1_d   = bus.id_rs1;
            ex_rs2_d   = bus.id_rs2;
            ex_rd_d    = bus.id_rd;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_imm_q     <= '0;
            ex_op_a_q    <= '0;
            ex_op_b_q    <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_imm_q     <= ex_imm_d;
            ex_op_a_q    <= ex_op_a_d;
            ex_op_b_q    <= ex_op_b_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall    = stall_c;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc    = ex_pc_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.ex_op_a  = ex_op_a_q;
    assign bus.ex_op_b  = ex_op_b_q;
    assign bus.ex_rs1   = ex_rs1_q;
    assign bus.ex_rs2   = ex_rs2_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_ctrl  = ex_ctrl_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps from the test plan followed by random
// traffic, all checked against a behavioural model of the ID/EX boundary.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int unsigned TB_XLEN  = 32;
    localparam int unsigned TB_CTRLW = 10;
    localparam int unsigned TB_CNTW  = 4;
    localparam int          CNT_TOP  = (1 << TB_CNTW) - 1;

    logic               clk;
    logic               rst;
    logic [TB_CNTW-1:0] bubble_cnt;

    id_ex_stage_if #(.XLEN(TB_XLEN), .CTRL_W(TB_CTRLW)) bus ();

    id_ex_stage #(.XLEN(TB_XLEN), .CTRL_W(TB_CTRLW), .CNT_W(TB_CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of what EX should hold
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_pc, m_imm, m_a, m_b;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    int          m_cnt;
    logic        pend_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_of(input logic mem_rd, input logic reg_wr);
        logic [9:0] c;
        c = '0;
        c[MEM_READ]  = mem_rd;
        c[REG_WRITE] = reg_wr;
        return c;
    endfunction

    // A load into register r stalls any valid ID instruction naming r as rs1 or rs2
    function automatic logic model_stall();
        if (rst || bus.flush || !bus.id_valid || !m_valid) return 1'b0;
        if (m_ctrl[MEM_READ] !== 1'b1 || m_rd == 5'd0) return 1'b0;
        return (m_rd == bus.id_rs1) || (m_rd == bus.id_rs2);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf);
        if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == rs) return bus.wb_data;
        return rf;
    endfunction

    task automatic model_edge(input logic s);
        if (rst) begin
            m_valid = 0; m_ctrl = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
        end else if (bus.flush) begin
            m_valid = 0; m_ctrl = 0;
        end else if (s) begin
            m_valid = 0; m_ctrl = 0;
            if (m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
        end else begin
            m_valid = bus.id_valid;
            m_ctrl  = bus.id_valid ? bus.id_ctrl : 10'd0;
            m_pc    = bus.id_pc;
            m_imm   = bus.id_imm;
            m_a     = src_val(bus.id_rs1, bus.id_data1);
            m_b     = src_val(bus.id_rs2, bus.id_data2);
            m_rs1   = bus.id_rs1;
            m_rs2   = bus.id_rs2;
            m_rd    = bus.id_rd;
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid",   32'(bus.ex_valid), 32'(m_valid));
        chk("ex_ctrl",    32'(bus.ex_ctrl),  32'(m_ctrl));
        chk("bubble_cnt", 32'(bubble_cnt),   32'(m_cnt));
        chk("ex_pc",      bus.ex_pc,   m_pc);
        chk("ex_imm",     bus.ex_imm,  m_imm);
        chk("ex_op_a",    bus.ex_op_a, m_a);
        chk("ex_op_b",    bus.ex_op_b, m_b);
        chk("ex_rs1",     32'(bus.ex_rs1), 32'(m_rs1));
        chk("ex_rs2",     32'(bus.ex_rs2), 32'(m_rs2));
        chk("ex_rd",      32'(bus.ex_rd),  32'(m_rd));
        chk("invariant",  32'(!bus.ex_valid && bus.ex_ctrl != 10'd0), 32'd0);
    endtask

    // Let inputs settle and check the combinational stall
    task automatic settle();
        #1;
        pend_stall = model_stall();
        chk("stall", 32'(bus.stall), 32'(pend_stall));
    endtask

    // Clock edge, then check registered outputs on the falling edge
    task automatic edge_check();
        @(posedge clk);
        model_edge(pend_stall);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick();
        settle();
        edge_check();
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [9:0] ctrl);
        bus.id_valid = v;   bus.id_pc = pc;     bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_rd = rd;     bus.id_data1 = d1;  bus.id_data2 = d2;
        bus.id_imm = imm;   bus.id_ctrl = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_reg_write = we; bus.wb_rd = rd; bus.wb_data = d;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        m_valid = 0; m_ctrl = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0; pend_stall = 0;
        @(negedge clk);

        // Reset for two cycles, then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_cnt",   32'(bubble_cnt),   32'd0);

        // Normal load
        set_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 32'h4, 10'h080);
        tick();
        chk("load_a",    bus.ex_op_a, 32'd8);
        chk("load_b",    bus.ex_op_b, 32'd9);
        chk("load_ctrl", 32'(bus.ex_ctrl), 32'h080);
        chk("load_vld",  32'(bus.ex_valid), 32'd1);

        // Bypass hit on rs1, then x0 never bypassed
        set_wb(1, 5'd7, 32'hDEAD);
        set_id(1, 32'h104, 5'd7, 5'd2, 5'd3, 32'd13, 32'd9, 32'h0, 10'h080);
        tick();
        chk("byp_hit", bus.ex_op_a, 32'hDEAD);
        set_wb(1, 5'd0, 32'hDEAD);
        set_id(1, 32'h108, 5'd0, 5'd2, 5'd3, 32'd13, 32'd9, 32'h0, 10'h080);
        tick();
        chk("byp_x0", bus.ex_op_a, 32'd13);
        set_wb(0, 0, 0);

        // Load-use: lw x5 in EX, ID reads x5 via rs2
        set_id(1, 32'h10C, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'h0, ctrl_of(1, 1));
        tick();
        set_id(1, 32'h110, 5'd6, 5'd5, 5'd8, 32'd3, 32'd4, 32'h0, 10'h080);
        settle();
        chk("lu_stall", 32'(bus.stall), 32'd1);
        edge_check();
        chk("lu_vld",  32'(bus.ex_valid), 32'd0);
        chk("lu_ctrl", 32'(bus.ex_ctrl),  32'd0);
        chk("lu_cnt",  32'(bubble_cnt),   32'd1);
        settle();
        chk("lu_release", 32'(bus.stall), 32'd0);
        edge_check();
        chk("lu_loaded", 32'(bus.ex_valid), 32'd1);

        // Flush wins over a load-use hazard
        set_id(1, 32'h114, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'h0, ctrl_of(1, 1));
        tick();
        set_id(1, 32'h118, 5'd5, 5'd0, 5'd9, 32'd3, 32'd4, 32'h0, 10'h080);
        bus.flush = 1'b1;
        settle();
        chk("fl_stall", 32'(bus.stall), 32'd0);
        edge_check();
        chk("fl_vld", 32'(bus.ex_valid), 32'd0);
        chk("fl_cnt", 32'(bubble_cnt),   32'd1);
        bus.flush = 1'b0;

        // Chain of dependent loads: alternating stall/load drives the counter to saturation
        set_id(1, 32'h200, 5'd5, 5'd5, 5'd5, 32'd1, 32'd2, 32'h0, ctrl_of(1, 1));
        for (int i = 0; i < 2 * (CNT_TOP + 4); i++) tick();
        chk("sat_cnt", 32'(bubble_cnt), 32'(CNT_TOP));

        // Reset during a hazard drops the stall and empties the pipe
        settle();
        edge_check();
        rst = 1'b1;
        tick();
        chk("rst_mid_vld", 32'(bus.ex_valid), 32'd0);
        chk("rst_mid_cnt", 32'(bubble_cnt),   32'd0);
        rst = 1'b0;

        // Random traffic over a small register set so hazards and bypasses are common
        for (int i = 0; i < 600; i++) begin
            logic [9:0] c;
            c = 10'($urandom_range(0, 1023));
            c[MEM_READ] = ($urandom_range(0, 1) == 1);
            set_id(($urandom_range(0, 9) < 8), $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, c);
            set_wb(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            bus.flush = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage RV32 core. Sits directly downstream of the register file.
- Captures the register-file read data, immediate, PC, register indices and decoded control for the EX stage.
- Applies a WB→ID write-through bypass, because the register file updates on the same clock edge it is read.
- Detects load-use hazards, inserts bubbles and honours branch flushes.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 10, width of the decoded control bundle.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_data1, id_data2  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle: [3:0] alu_op, [4] alu_src, [5] mem_read, [6] mem_write, [7] reg_write, [8] mem_to_reg, [9] branch.
- wb_reg_write  in  1  writeback enable into the register file.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  branch taken in EX; the ID instruction is squashed.
- stall  out  1  combinational; hold PC and IF/ID.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_imm  out  XLEN  registered copies.
- ex_op_a, ex_op_b  out  XLEN  registered (bypassed) rs1/rs2 data.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices.
- ex_ctrl  out  CTRL_W  registered control.
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs registered to 0, including ex_valid, ex_ctrl and bubble_cnt.
  - stall is forced to 0 while rst=1.
- Bypass (combinational, per operand):
  - Operand 1 uses wb_data when wb_reg_write & wb_rd!=0 & wb_rd==id_rs1; otherwise it uses id_data1.
  - Operand 2 follows the same rule with id_rs2 / id_data2.
  - x0 is never bypassed.
- Load-use hazard:
  - stall = id_valid & ex_valid & ex_ctrl[5] & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & ~flush.
  - Both rs fields are compared even when the instruction type ignores rs2. This is a deliberate, conservative false stall.
- Next-state priority at each edge: rst > flush > stall > load.
  - flush: ex_valid←0, ex_ctrl←0; data fields are don't-care (held); bubble_cnt unchanged. Squashes are not counted as bubbles.
  - stall: ex_valid←0, ex_ctrl←0; bubble_cnt increments, saturating at all-ones.
  - load: ex_valid←id_valid; ex_ctrl←id_ctrl when id_valid=1, else 0. All data/index fields captured; operands take the bypassed values.
- Latency and stall duration:
  - 1 cycle from ID inputs to EX outputs.
  - A stall lasts exactly 1 cycle, because the bubble clears ex_valid.
- Bubble invariant: ex_valid=0 implies ex_ctrl=0, so no reg_write or mem_write can leak downstream.
- Simultaneous flush and hazard: flush wins; stall=0; one squash, no count.
- Reset mid-stall: the stall is dropped; the pipeline restarts empty.

Decomposition:
- Shared package:
  - Control-bit index constants: ALU_OP_LSB/MSB, ALU_SRC, MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG, BRANCH.
  - CTRL_W.
  - Register index width 5.
  - Constant X0 = 5'd0.
- Sub-module: hazard_detect, combinational, producing stall from the ex_* and id_* fields. The pipeline register, bypass and counter remain in id_ex_stage.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with id_valid=0 → all outputs 0, stall=0, bubble_cnt=0.
- Normal load: id_rs1=1, id_rs2=2, id_data1=8, id_data2=9, id_ctrl=10'h080, id_valid=1 → next cycle ex_op_a=8, ex_op_b=9, ex_ctrl=10'h080, ex_valid=1.
- WB bypass:
  - Case 1: wb_reg_write=1, wb_rd=7, wb_data=32'hDEAD, id_rs1=7, id_data1=13 → ex_op_a=32'hDEAD.
  - Case 2: same stimulus with wb_rd=0 and id_rs1=0 → ex_op_a=id_data1.
- Load-use:
  - Setup: EX holds lw with ex_rd=5, ctrl[5]=1; ID has id_rs2=5.
  - Required: stall=1 for exactly one cycle; next ex_valid=0, ex_ctrl=0, bubble_cnt=1.
  - Then, with ID held: stall=0 and the instruction loads.
- Flush priority: the load-use condition plus flush=1 → stall=0, ex_valid=0, bubble_cnt unchanged.
- Saturation: force 2^CNT_W+3 stalls → bubble_cnt=all-ones; no wrap.
